// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the CPU front end (fetch unit and sequencer).
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        FETCH_CB = 2'd2,
        HALTED   = 2'd3
    } fetch_state_t;

    localparam logic [7:0] CB_PREFIX_BYTE = 8'hCB;

endpackage

// File: rtl/gb_cpu_tcycle_counter.sv
// Free-running T-cycle counter; four T-cycles per M-cycle, tcnt==0 starts one.
module gb_cpu_tcycle_counter (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] tcnt,
    output logic       mcycle_start
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else
            tcnt <= tcnt + 2'd1;
    end

    assign mcycle_start = (tcnt == 2'd0);

endmodule

// File: rtl/gb_cpu_fetch_unit.sv
// Opcode fetch unit: one M-cycle per byte, 0xCB prefix handling, HALT blocking.
// Define GB_CPU_HALT_BUG_EN to suppress pc_inc on the first fetch after HALT.
module gb_cpu_fetch_unit
    import gb_cpu_common_pkg::*;
#(
    parameter logic [7:0] RESET_OPCODE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        halt,
    input  logic [15:0] pc,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        pc_inc,
    output logic [7:0]  opcode,
    output logic        cb_prefix,
    output logic        instr_valid,
    output logic        busy
);

    fetch_state_t state, next_state;
    logic [1:0]   tcnt;
    logic         mcycle_start;
    logic         last_t;
    logic         load_op;
    logic         set_cb_pending;
    logic         cb_pending;
    logic         iv_q;
    logic         pc_inc_suppress;
    logic         arm_halt_bug;
    logic         clear_halt_bug;

    gb_cpu_tcycle_counter u_tcnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .tcnt         (tcnt),
        .mcycle_start (mcycle_start)
    );

    assign last_t = (tcnt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        mem_rd         = 1'b0;
        mem_addr       = '0;
        busy           = 1'b0;
        pc_inc         = 1'b0;
        load_op        = 1'b0;
        set_cb_pending = 1'b0;
        arm_halt_bug   = 1'b0;
        clear_halt_bug = 1'b0;
        case (state)
            IDLE: begin
                if (last_t) begin
                    if (halt)
                        next_state = HALTED;
                    else if (fetch_start)
                        next_state = FETCH;
                end
            end
            FETCH, FETCH_CB: begin
                mem_rd   = 1'b1;
                mem_addr = pc;
                busy     = 1'b1;
                if (last_t) begin
                    pc_inc         = !pc_inc_suppress;
                    clear_halt_bug = 1'b1;
                    // Only a plain FETCH treats 0xCB as a prefix; in FETCH_CB it is an opcode.
                    if (state == FETCH && mem_rdata == CB_PREFIX_BYTE) begin
                        set_cb_pending = 1'b1;
                        next_state     = FETCH_CB;
                    end else begin
                        load_op    = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            HALTED: begin
                if (last_t && !halt) begin
                    if (fetch_start) begin
                        next_state   = FETCH;
                        arm_halt_bug = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode     <= RESET_OPCODE;
            cb_prefix  <= 1'b0;
            cb_pending <= 1'b0;
            iv_q       <= 1'b0;
        end else begin
            iv_q <= load_op;
            if (load_op) begin
                opcode     <= mem_rdata;
                cb_prefix  <= cb_pending;
                cb_pending <= 1'b0;
            end else if (set_cb_pending) begin
                cb_pending <= 1'b1;
            end
        end
    end

    assign instr_valid = iv_q && mcycle_start;

`ifdef GB_CPU_HALT_BUG_EN
    logic halt_bug_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halt_bug_armed <= 1'b0;
        else if (arm_halt_bug)
            halt_bug_armed <= 1'b1;
        else if (clear_halt_bug)
            halt_bug_armed <= 1'b0;
    end

    assign pc_inc_suppress = halt_bug_armed;
`else
    logic unused_halt_bug;

    assign unused_halt_bug = arm_halt_bug ^ clear_halt_bug;
    assign pc_inc_suppress = 1'b0;
`endif

endmodule

// File: doc/gb_cpu_fetch_unit.md
GB_CPU_FETCH_UNIT -- requirements
Module: gb_cpu_fetch_unit

Interface
- REQ-001 SHALL have parameter RESET_OPCODE, default 8'h00 (NOP), the IR value after reset.
- REQ-002 SHALL have port clk, input, 1, CPU clock; one T-cycle per rising edge.
- REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assertion, active-low.
- REQ-004 SHALL have port fetch_start, input, 1, sequencer request to fetch the next opcode in the following M-cycle.
- REQ-005 SHALL have port halt, input, 1, CPU in HALT state; this blocks fetching.
- REQ-006 SHALL have port pc, input, 16, current program counter.
- REQ-007 SHALL have port mem_rdata, input, 8, memory read data.
- REQ-008 SHALL have port mem_addr, output, 16, memory address.
- REQ-009 SHALL have port mem_rd, output, 1, memory read strobe.
- REQ-010 SHALL have port pc_inc, output, 1, one-clock pulse telling the PC owner to increment the PC.
- REQ-011 SHALL have port opcode, output, 8, instruction register value sent to the decoder.
- REQ-012 SHALL have port cb_prefix, output, 1, set when opcode was preceded by 0xCB; sent to the decoder.
- REQ-013 SHALL have port instr_valid, output, 1, one-clock pulse meaning opcode/cb_prefix are new.
- REQ-014 SHALL have port busy, output, 1, high while a fetch M-cycle is in progress.

Function
- REQ-015 SHALL keep a free-running 2-bit T-cycle counter tcnt, 0..3, wrapping 3->0; tcnt==0 marks the start of an M-cycle.
- REQ-016 SHALL implement states IDLE, FETCH, FETCH_CB and HALTED.
- REQ-017 SHALL sample fetch_start and halt only when tcnt==3.
- REQ-018 In IDLE, at tcnt==3: halt=1 -> HALTED; else fetch_start=1 -> FETCH; else stay in IDLE.
- REQ-019 In FETCH or FETCH_CB, for all four T-cycles: mem_rd=1, mem_addr=pc, busy=1.
- REQ-020 In IDLE or HALTED: mem_rd=0, mem_addr=16'h0000, busy=0.
- REQ-021 SHALL capture mem_rdata at tcnt==3 of a fetch M-cycle and pulse pc_inc in that same clock.
- REQ-022 In FETCH, a captured byte of 8'hCB SHALL set internal cb_pending, go to FETCH_CB, and update neither opcode nor instr_valid.
- REQ-023 In FETCH, any other captured byte SHALL load opcode, set cb_prefix=0, and go to IDLE.
- REQ-024 In FETCH_CB, any captured byte, including 8'hCB, SHALL load opcode, set cb_prefix=1, clear cb_pending, and go to IDLE.
- REQ-025 instr_valid SHALL pulse for exactly one clock, at tcnt==0 after a load; latency from fetch_start sampled to instr_valid is 5 clocks, or 9 for a CB-prefixed opcode.
- REQ-026 opcode and cb_prefix SHALL hold stable between loads.
- REQ-027 fetch_start asserted during FETCH, FETCH_CB or HALTED SHALL be ignored and not queued.
- REQ-028 In HALTED, at tcnt==3 with halt=0: fetch_start=1 -> FETCH; else -> IDLE.
- REQ-029 halt asserted in FETCH or FETCH_CB SHALL NOT abort the fetch; it is acted on from IDLE.

Reset
- REQ-030 rst_n=0 SHALL immediately set state=IDLE, tcnt=0, opcode=RESET_OPCODE, cb_prefix=0, cb_pending=0, instr_valid=0, pc_inc=0, mem_rd=0, mem_addr=0, busy=0.
- REQ-031 Reset in mid-fetch SHALL discard the partial fetch with no pc_inc pulse.
- REQ-032 After rst_n deasserts, the first sampling point SHALL be the fourth rising edge.

Configuration
- REQ-033 Macro GB_CPU_HALT_BUG_EN, when defined, SHALL model the DMG HALT bug: the first fetch after HALTED->FETCH captures data but suppresses its pc_inc pulse.
- REQ-034 With GB_CPU_HALT_BUG_EN undefined, every fetch SHALL pulse pc_inc.

Structure
- REQ-035 The fetch_state_t enum and the CB_PREFIX_BYTE=8'hCB constant SHALL live in gb_cpu_common_pkg.
- REQ-036 The T-cycle counter SHALL be a sub-module gb_cpu_tcycle_counter, exposing tcnt and an M-cycle strobe, for reuse by the sequencer.

Verification
- REQ-037 Reset then fetch_start=1 with mem_rdata=8'h80 -> mem_rd high for 4 clocks, mem_addr=pc, pc_inc 1 pulse, opcode=8'h80, cb_prefix=0, instr_valid 1 pulse 5 clocks after sampling.
- REQ-038 fetch_start with mem_rdata 8'hCB then 8'h37 -> 2 fetch M-cycles, 2 pc_inc pulses, opcode=8'h37, cb_prefix=1, single instr_valid.
- REQ-039 fetch_start held high during FETCH -> exactly one fetch and one instr_valid.
- REQ-040 halt=1 in IDLE, fetch_start=1 -> no mem_rd; drop halt -> fetch proceeds; with GB_CPU_HALT_BUG_EN defined, no pc_inc on that fetch.
- REQ-041 rst_n low at tcnt==2 of FETCH -> opcode=RESET_OPCODE, no pc_inc, no instr_valid, state IDLE.
- REQ-042 Two CB-prefixed fetches back-to-back -> cb_prefix=1 for each, cb_pending never leaks into a following plain opcode (cb_prefix=0).
